// File: rtl/zihpm_counters_if.sv
// CSR/event port bundle for the hpm counter block: the pipeline and CSR unit drive it, the counters serve it.
// Latency: wires only. Read data, hit and illegal are combinational in the block behind the slave modport.
// Backpressure: none. Events are per-cycle pulses and a CSR write strobe lasts one cycle.
// Signals: Events (event pulses, bit 0 = event id 1), CsrAddr, CsrWriteEn, CsrWriteData,
//          CsrReadData, CsrHit, CsrIllegal, plus OverflowIrq when ZIHPM_OVERFLOW_IRQ_EN is defined.
interface zihpm_counters_if #(
  parameter int XLEN       = 32,
  parameter int NUM_EVENTS = 8
);
  logic [NUM_EVENTS-1:0] Events;
  logic [11:0]           CsrAddr;
  logic                  CsrWriteEn;
  logic [XLEN-1:0]       CsrWriteData;
  logic [XLEN-1:0]       CsrReadData;
  logic                  CsrHit;
  logic                  CsrIllegal;
`ifdef ZIHPM_OVERFLOW_IRQ_EN
  logic                  OverflowIrq;

  modport master (
    output Events, CsrAddr, CsrWriteEn, CsrWriteData,
    input  CsrReadData, CsrHit, CsrIllegal, OverflowIrq
  );
  modport slave (
    input  Events, CsrAddr, CsrWriteEn, CsrWriteData,
    output CsrReadData, CsrHit, CsrIllegal, OverflowIrq
  );
`else
  modport master (
    output Events, CsrAddr, CsrWriteEn, CsrWriteData,
    input  CsrReadData, CsrHit, CsrIllegal
  );
  modport slave (
    input  Events, CsrAddr, CsrWriteEn, CsrWriteData,
    output CsrReadData, CsrHit, CsrIllegal
  );
`endif
endinterface

// File: rtl/zihpm_counters.sv
// Zihpm performance monitor: NUM_COUNTERS event-selectable counters, their selectors and mcountinhibit.
// Latency: CSR reads are combinational; writes and increments land on the next clk edge.
// Backpressure: none. Every event pulse and every CSR write is taken in the cycle it is presented.
// Ports: clk; reset (async, active low); bus (zihpm_counters_if.slave) carries Events, the CSR
//        read/write port, CsrHit/CsrIllegal and, with ZIHPM_OVERFLOW_IRQ_EN defined, OverflowIrq.
// Optional feature macro: ZIHPM_OVERFLOW_IRQ_EN adds the OF/MINH bits of mhpmevent and OverflowIrq.
module zihpm_counters #(
  parameter int XLEN          = 32,
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  zihpm_counters_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_EVENTS + 1);
  // Event vector padded so every stored select value indexes a real bit:
  // bit 0 (select 0) and bits above NUM_EVENTS are tied low, so they never count.
  localparam int EV_W  = 1 << SEL_W;

  localparam logic [11:0] ADDR_INH  = 12'h320;
  localparam logic [11:0] EVT_BASE  = 12'h323;
  localparam logic [11:0] CNT_BASE  = 12'hB03;
  localparam logic [11:0] CNTH_BASE = 12'hB83;
  localparam logic [11:0] RO_BASE   = 12'hC03;
  localparam logic [11:0] ROH_BASE  = 12'hC83;

  function automatic logic [63:0] ext64(input logic [COUNTER_WIDTH-1:0] v);
    return 64'(v);
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_q    [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_wval [NUM_COUNTERS];
  logic [SEL_W-1:0]         sel_q    [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  inh_q;

  logic                     inh_sel;
  logic [NUM_COUNTERS-1:0]  evt_sel, lo_sel, hi_sel, rlo_sel, rhi_sel;
  logic [NUM_COUNTERS-1:0]  cnt_wr, inc;
  logic [EV_W-1:0]          ev_ext;
  logic [XLEN-1:0]          rdata;
  logic                     hit, illegal;

`ifdef ZIHPM_OVERFLOW_IRQ_EN
  logic [NUM_COUNTERS-1:0]  of_q, of_d, minh_q, wrap;
  logic                     irq_q;
`endif

  assign ev_ext = EV_W'({bus.Events, 1'b0});

  // Address decode. The high-half aliases only exist on a 32-bit CSR file.
  always_comb begin
    inh_sel = (bus.CsrAddr == ADDR_INH);
    evt_sel = '0;
    lo_sel  = '0;
    hi_sel  = '0;
    rlo_sel = '0;
    rhi_sel = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      evt_sel[i] = (bus.CsrAddr == EVT_BASE + 12'(i));
      lo_sel[i]  = (bus.CsrAddr == CNT_BASE + 12'(i));
      rlo_sel[i] = (bus.CsrAddr == RO_BASE  + 12'(i));
      hi_sel[i]  = (XLEN == 32) && (bus.CsrAddr == CNTH_BASE + 12'(i));
      rhi_sel[i] = (XLEN == 32) && (bus.CsrAddr == ROH_BASE  + 12'(i));
    end
  end

  // Read mux, hit and illegal-write flags.
  always_comb begin
    rdata   = '0;
    hit     = inh_sel | (|evt_sel) | (|lo_sel) | (|hi_sel) | (|rlo_sel) | (|rhi_sel);
    illegal = bus.CsrWriteEn & ((|rlo_sel) | (|rhi_sel));
    if (inh_sel) rdata = XLEN'({inh_q, 3'b000});
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (evt_sel[i]) begin
        rdata = XLEN'(sel_q[i]);
`ifdef ZIHPM_OVERFLOW_IRQ_EN
        rdata[XLEN-1] = of_q[i];
        rdata[XLEN-2] = minh_q[i];
`endif
      end
      if (lo_sel[i] | rlo_sel[i]) rdata = XLEN'(ext64(cnt_q[i]));
      if (hi_sel[i] | rhi_sel[i]) rdata = XLEN'(ext64(cnt_q[i]) >> 32);
    end
  end

  // Counter write value and increment enables. A half write only replaces its own
  // half and suppresses the increment, so nothing carries across halves that cycle.
  always_comb begin
    logic [63:0] wd64, cur, nxt;
    wd64   = 64'(bus.CsrWriteData);
    cur    = '0;
    nxt    = '0;
    cnt_wr = '0;
    inc    = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cur = ext64(cnt_q[i]);
      nxt = wd64;
      if (XLEN == 32) begin
        if (hi_sel[i]) nxt = {wd64[31:0], cur[31:0]};
        else           nxt = {cur[63:32], wd64[31:0]};
      end
      cnt_wval[i] = COUNTER_WIDTH'(nxt);
      cnt_wr[i]   = bus.CsrWriteEn & (lo_sel[i] | hi_sel[i]);
      inc[i]      = ev_ext[sel_q[i]] & ~inh_q[i] & ~cnt_wr[i];
`ifdef ZIHPM_OVERFLOW_IRQ_EN
      inc[i]      = inc[i] & ~minh_q[i];
`endif
    end
  end

`ifdef ZIHPM_OVERFLOW_IRQ_EN
  // OF: a hardware wrap beats a software write in the same cycle.
  always_comb begin
    wrap = '0;
    of_d = of_q;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      wrap[i] = inc[i] & (&cnt_q[i]);
      if (wrap[i])                             of_d[i] = 1'b1;
      else if (bus.CsrWriteEn & evt_sel[i])    of_d[i] = bus.CsrWriteData[XLEN-1];
    end
  end

  assign bus.OverflowIrq = irq_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      inh_q <= '0;
`ifdef ZIHPM_OVERFLOW_IRQ_EN
      of_q   <= '0;
      minh_q <= '0;
      irq_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (cnt_wr[i])   cnt_q[i] <= cnt_wval[i];
        else if (inc[i]) cnt_q[i] <= cnt_q[i] + COUNTER_WIDTH'(1);
        if (bus.CsrWriteEn & evt_sel[i]) begin
          sel_q[i] <= bus.CsrWriteData[SEL_W-1:0];
`ifdef ZIHPM_OVERFLOW_IRQ_EN
          minh_q[i] <= bus.CsrWriteData[XLEN-2];
`endif
        end
      end
      if (bus.CsrWriteEn & inh_sel) inh_q <= bus.CsrWriteData[3 +: NUM_COUNTERS];
`ifdef ZIHPM_OVERFLOW_IRQ_EN
      of_q  <= of_d;
      // Tracks the OR of the OF bits as they stand after this edge.
      irq_q <= |of_d;
`endif
    end
  end

  assign bus.CsrReadData = rdata;
  assign bus.CsrHit      = hit;
  assign bus.CsrIllegal  = illegal;

endmodule

// File: tb/tb_zihpm_counters.sv
// Bench for zihpm_counters (XLEN=32, 4 counters, 8 events, 64-bit counters).
// Fixed vector table, random traffic against a behavioural model, and hand sequences
// for asynchronous reset and, when ZIHPM_OVERFLOW_IRQ_EN is defined, overflow.
module tb_zihpm_counters;
  localparam int NC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  zihpm_counters_if #(.XLEN(32), .NUM_EVENTS(8)) bus ();

  zihpm_counters #(
    .XLEN(32), .NUM_COUNTERS(NC), .NUM_EVENTS(8), .COUNTER_WIDTH(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [7:0]  ev;
    bit          we;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          hit;
    bit          ill;
  } vec_t;
  vec_t tbl[$];

  // ---------------- behavioural model ----------------
  longint unsigned m_cnt [NC];
  int unsigned     m_sel [NC];
  bit              m_inh [NC];
  bit              m_of  [NC];
  bit              m_minh[NC];

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_sel[i] = 0; m_inh[i] = 0; m_of[i] = 0; m_minh[i] = 0;
    end
  endfunction

  function automatic bit m_irq();
    bit any = 0;
    for (int i = 0; i < NC; i++) any |= m_of[i];
    return any;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit hit);
    int ai = int'(a);
    logic [31:0] r = 0;
    hit = 0;
    if (ai == 'h320) begin
      hit = 1;
      for (int i = 0; i < NC; i++) r[3+i] = m_inh[i];
    end
    for (int i = 0; i < NC; i++) begin
      if (ai == 'h323 + i) begin
        hit = 1;
        r = 32'(m_sel[i]);
        r[31] = m_of[i];
        r[30] = m_minh[i];
      end
      if (ai == 'hB03 + i || ai == 'hC03 + i) begin
        hit = 1; r = 32'(m_cnt[i] % 64'h1_0000_0000);
      end
      if (ai == 'hB83 + i || ai == 'hC83 + i) begin
        hit = 1; r = 32'(m_cnt[i] / 64'h1_0000_0000);
      end
    end
    return r;
  endfunction

  function automatic bit m_illegal(input bit we, input logic [11:0] a);
    int ai = int'(a);
    bit ro = 0;
    for (int i = 0; i < NC; i++) if (ai == 'hC03 + i || ai == 'hC83 + i) ro = 1;
    return we && ro;
  endfunction

  // One clock edge worth of architectural effect, from the pre-edge state.
  function automatic void m_step(input logic [7:0] ev, input bit we, input logic [11:0] a,
                                 input logic [31:0] wd);
    int ai = int'(a);
    for (int i = 0; i < NC; i++) begin
      bit wr_lo = we && (ai == 'hB03 + i);
      bit wr_hi = we && (ai == 'hB83 + i);
      int s = int'(m_sel[i]);
      bit counts = (s >= 1) && (s <= 8) && !m_inh[i] && !m_minh[i] && !wr_lo && !wr_hi;
      bit wrapped = 0;
      if (counts) counts = ev[s-1];
      if (wr_lo)      m_cnt[i] = (m_cnt[i] / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(wd);
      else if (wr_hi) m_cnt[i] = (64'(wd) * 64'h1_0000_0000) + (m_cnt[i] % 64'h1_0000_0000);
      else if (counts) begin
        wrapped  = (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF);
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (we && ai == 'h323 + i) begin
        m_sel[i] = wd % 16;
`ifdef ZIHPM_OVERFLOW_IRQ_EN
        m_of[i]   = wd[31];
        m_minh[i] = wd[30];
`endif
      end
`ifdef ZIHPM_OVERFLOW_IRQ_EN
      if (wrapped) m_of[i] = 1;
`endif
      if (we && ai == 'h320) m_inh[i] = wd[3+i];
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Present one cycle of inputs, check the combinational outputs, then clock it.
  task automatic apply(input vec_t v);
    bus.Events       = v.ev;
    bus.CsrAddr      = v.a;
    bus.CsrWriteEn   = v.we;
    bus.CsrWriteData = v.wd;
    #1;
    chk({v.nm, ".rd"},  bus.CsrReadData, v.rd);
    chk({v.nm, ".hit"}, 32'(bus.CsrHit), 32'(v.hit));
    chk({v.nm, ".ill"}, 32'(bus.CsrIllegal), 32'(v.ill));
`ifdef ZIHPM_OVERFLOW_IRQ_EN
    chk({v.nm, ".irq"}, 32'(bus.OverflowIrq), 32'(m_irq()));
`endif
    m_step(v.ev, v.we, v.a, v.wd);
    @(negedge clk);
  endtask

  // Same, with expectations taken from the model.
  task automatic am(input string nm, input logic [7:0] ev, input bit we, input logic [11:0] a,
                    input logic [31:0] wd);
    vec_t v;
    bit h;
    v.nm = nm; v.ev = ev; v.we = we; v.a = a; v.wd = wd;
    v.rd = m_read(a, h);
    v.hit = h;
    v.ill = m_illegal(we, a);
    apply(v);
  endtask

  task automatic add(input string nm, input logic [7:0] ev, input bit we, input logic [11:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input bit hit, input bit ill);
    vec_t v;
    v.nm = nm; v.ev = ev; v.we = we; v.a = a; v.wd = wd; v.rd = rd; v.hit = hit; v.ill = ill;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] addrs[$];
    logic [31:0] wd;

    bus.Events = '0; bus.CsrAddr = '0; bus.CsrWriteEn = 1'b0; bus.CsrWriteData = '0;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // ---- fixed vector table ----
    add("rst_b03",   8'h00, 0, 12'hB03, 0, 0, 1, 0);
    add("rst_323",   8'h00, 0, 12'h323, 0, 0, 1, 0);
    add("rst_320",   8'h00, 0, 12'h320, 0, 0, 1, 0);
    add("nohit_b1f", 8'h00, 0, 12'hB1F, 0, 0, 0, 0);
    add("nohit_327", 8'h00, 0, 12'h327, 0, 0, 0, 0);
    add("wr_sel3",   8'h00, 1, 12'h323, 32'hF2, 0, 1, 0);
    add("rd_sel3",   8'h00, 0, 12'h323, 0, 2, 1, 0);
    for (int k = 0; k < 10; k++) add($sformatf("cnt3_%0d", k), 8'h02, 0, 12'hB03, 0, k, 1, 0);
    add("other_ev",  8'hFD, 0, 12'hB03, 0, 10, 1, 0);
    add("cnt4_idle", 8'h00, 0, 12'hB04, 0, 0, 1, 0);
    add("wr_inh",    8'h02, 1, 12'h320, 32'hFFFF_FFFF, 0, 1, 0);
    add("rd_inh",    8'h02, 0, 12'h320, 0, 32'h78, 1, 0);
    add("inh_hold1", 8'h02, 0, 12'hB03, 0, 11, 1, 0);
    add("inh_hold2", 8'h02, 0, 12'hB03, 0, 11, 1, 0);
    add("clr_inh",   8'h00, 1, 12'h320, 0, 32'h78, 1, 0);
    add("wr_vs_inc", 8'h02, 1, 12'hB03, 100, 11, 1, 0);
    add("after_wr",  8'h02, 0, 12'hB03, 0, 100, 1, 0);
    add("after_inc", 8'h00, 0, 12'hB03, 0, 101, 1, 0);
    add("ill_c03",   8'h00, 1, 12'hC03, 32'h55, 101, 1, 1);
    add("c03_kept",  8'h00, 0, 12'hB03, 0, 101, 1, 0);
    add("rd_c03",    8'h00, 0, 12'hC03, 0, 101, 1, 0);
    add("wr_lo_ff",  8'h00, 1, 12'hB03, 32'hFFFF_FFFF, 101, 1, 0);
    add("wr_hi_0",   8'h02, 1, 12'hB83, 0, 0, 1, 0);
    add("carry_pre", 8'h02, 0, 12'hB03, 0, 32'hFFFF_FFFF, 1, 0);
    add("carry_lo",  8'h00, 0, 12'hB03, 0, 0, 1, 0);
    add("carry_hi",  8'h00, 0, 12'hB83, 0, 1, 1, 0);
    add("ones_lo",   8'h00, 1, 12'hB03, 32'hFFFF_FFFF, 0, 1, 0);
    add("ones_hi",   8'h00, 1, 12'hB83, 32'hFFFF_FFFF, 1, 1, 0);
    add("wrap_pre",  8'h02, 0, 12'hB83, 0, 32'hFFFF_FFFF, 1, 0);
    add("wrap_lo",   8'h00, 0, 12'hB03, 0, 0, 1, 0);
    add("wrap_hi",   8'h00, 0, 12'hB83, 0, 0, 1, 0);
    add("hi_wr_ev",  8'h02, 1, 12'hB83, 5, 0, 1, 0);
    add("hi_keep_lo",8'h00, 0, 12'hB03, 0, 0, 1, 0);
    add("hi_val",    8'h00, 0, 12'hB83, 0, 5, 1, 0);
    add("rd_c83",    8'h00, 0, 12'hC83, 0, 5, 1, 0);
    add("wr_b84",    8'h00, 1, 12'hB84, 7, 0, 1, 0);
    add("rd_c84",    8'h00, 0, 12'hC84, 0, 7, 1, 0);
    add("unowned_wr",8'h00, 1, 12'h000, 32'h1234, 0, 0, 0);
    add("unowned_rd",8'h00, 0, 12'h3A0, 0, 0, 0, 0);
    add("wr_sel4_9", 8'h00, 1, 12'h324, 9, 0, 1, 0);
    add("rd_sel4_9", 8'hFF, 0, 12'h324, 0, 9, 1, 0);
    add("sel9_lo",   8'hFF, 0, 12'hB04, 0, 0, 1, 0);
    add("sel9_hi",   8'hFF, 0, 12'hB84, 0, 7, 1, 0);
    add("ill_c84",   8'h00, 1, 12'hC84, 1, 7, 1, 1);
    add("c84_kept",  8'h00, 0, 12'hB84, 0, 7, 1, 0);
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    // ---- random traffic against the model ----
    addrs.push_back(12'h320); addrs.push_back(12'h327); addrs.push_back(12'hB07);
    addrs.push_back(12'hB1F); addrs.push_back(12'h000);
    for (int i = 0; i < NC; i++) begin
      addrs.push_back(12'(12'h323 + i)); addrs.push_back(12'(12'h323 + i));
      addrs.push_back(12'(12'hB03 + i)); addrs.push_back(12'(12'hB83 + i));
      addrs.push_back(12'(12'hC03 + i)); addrs.push_back(12'(12'hC83 + i));
    end
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'($urandom_range(0, 20));
        default: wd = $urandom;
      endcase
      am("rand", 8'($urandom), $urandom_range(0, 3) == 0,
         addrs[$urandom_range(0, addrs.size() - 1)], wd);
    end

    // ---- reset asserted mid-count, away from any clock edge ----
    am("pre_rst_sel", 8'h00, 1, 12'h323, 1);
    am("pre_rst_cnt", 8'h00, 1, 12'hB03, 32'h1234);
    am("pre_rst_run", 8'h01, 0, 12'hB03, 0);
    bus.Events = 8'hFF; bus.CsrWriteEn = 1'b0; bus.CsrAddr = 12'hB03;
    #2 reset = 1'b0;
    #1 chk("async_rst_b03", bus.CsrReadData, 0);
    chk("async_rst_hit", 32'(bus.CsrHit), 1);
    bus.CsrAddr = 12'h323;
    #1 chk("async_rst_323", bus.CsrReadData, 0);
    bus.CsrAddr = 12'h320;
    #1 chk("async_rst_320", bus.CsrReadData, 0);
    @(negedge clk);
    m_reset();
    reset = 1'b1;
    am("post_rst_b03", 8'h00, 0, 12'hB03, 0);

`ifdef ZIHPM_OVERFLOW_IRQ_EN
    // ---- overflow flag and interrupt ----
    add("of_sel",    8'h00, 1, 12'h323, 2, 0, 1, 0);
    tbl.delete();
    add("of_sel",    8'h00, 1, 12'h323, 2, 0, 1, 0);
    add("of_lo",     8'h00, 1, 12'hB03, 32'hFFFF_FFFF, 0, 1, 0);
    add("of_hi",     8'h00, 1, 12'hB83, 32'hFFFF_FFFF, 0, 1, 0);
    add("of_wrap",   8'h02, 0, 12'hB03, 0, 32'hFFFF_FFFF, 1, 0);
    add("of_set",    8'h00, 0, 12'h323, 0, 32'h8000_0002, 1, 0);
    add("of_clr",    8'h00, 1, 12'h323, 2, 32'h8000_0002, 1, 0);
    add("of_clred",  8'h00, 0, 12'h323, 0, 2, 1, 0);
    add("of_lo2",    8'h00, 1, 12'hB03, 32'hFFFF_FFFF, 0, 1, 0);
    add("of_hi2",    8'h00, 1, 12'hB83, 32'hFFFF_FFFF, 0, 1, 0);
    add("of_race",   8'h02, 1, 12'h323, 2, 2, 1, 0);
    add("of_hw_wins",8'h00, 0, 12'h323, 0, 32'h8000_0002, 1, 0);
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      if (tbl[k].nm == "of_wrap") chk("of_irq_set", 32'(bus.OverflowIrq), 1);
      if (tbl[k].nm == "of_clr")  chk("of_irq_clr", 32'(bus.OverflowIrq), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/zihpm_counters.md
Name: zihpm_counters

Overview:
Parametrised hardware performance monitor (Zihpm) block that generalises the fixed Zicntr cycle/time/instret counters. It provides NUM_COUNTERS event-selectable counters (mhpmcounter3..), their mhpmevent selectors and mcountinhibit, all held internally. The block sits in the computational stage's CSR unit beside the Zicntr counters. It is driven by a per-cycle event bus from the pipeline and by the CSR read/write port.

Parameters:
XLEN, 32, CSR data width; 32 or 64 only.
NUM_COUNTERS, 4, implemented hpm counters 3..3+NUM_COUNTERS-1; legal range 1..29.
NUM_EVENTS, 8, width of the Events bus.
COUNTER_WIDTH, 64, implemented counter bits (40..64); upper bits read 0.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
Events  input  NUM_EVENTS  per-cycle event pulses, one bit per event class (bit 0 = event id 1).
CsrAddr  input  12  CSR address.
CsrWriteEn  input  1  CSR write strobe, valid for one cycle.
CsrWriteData  input  XLEN  CSR write value, already resolved for CSRRW/S/C.
CsrReadData  output  XLEN  combinational read data for CsrAddr.
CsrHit  output  1  CsrAddr decodes to a CSR owned by this block.
CsrIllegal  output  1  CsrWriteEn is asserted to a read-only alias.

Behaviour:
- Address map: mcountinhibit 0x320; mhpmevent(3+i) 0x323+i; mhpmcounter(3+i) 0xB03+i; hpmcounter(3+i) 0xC03+i (read-only). For XLEN=32 only: mhpmcounter(3+i)h 0xB83+i and hpmcounter(3+i)h 0xC83+i (read-only). Unimplemented indices give CsrHit=0.
- Reset (reset low, asynchronous): all counters = 0; all mhpmevent = 0; mcountinhibit = 0; CsrIllegal = 0. CsrReadData and CsrHit follow CsrAddr combinationally, so after reset they return 0 for any implemented CSR.
- mhpmevent is WARL. The low clog2(NUM_EVENTS+1) bits are stored and all other bits read 0. Select value 0, or a value greater than NUM_EVENTS, means the counter does not count. Out-of-range values are stored as written.
- mcountinhibit bits 3..3+NUM_COUNTERS-1 are writable; all other bits read 0. A set bit freezes the matching counter.
- Increment rule, per cycle: counter i increments by 1 when all of these hold:
  - its select s is in 1..NUM_EVENTS;
  - Events[s-1] is 1;
  - its inhibit bit is 0;
  - it is not being written this cycle.
- Wrap-around: the counter wraps from 2^COUNTER_WIDTH-1 to 0 with no other side effect, except the optional feature below.
- Write latency: a write at edge t is visible on CsrReadData from cycle t+1. A counter read returns the registered value, which excludes any increment in the current cycle.
- Write vs increment in the same cycle: the write wins, and no increment is applied in that cycle.
- XLEN=32 half-word writes:
  - writing the low half replaces bits 31:0 and keeps the high half;
  - writing the h CSR replaces bits COUNTER_WIDTH-1:32 and keeps the low half.
  - Neither half-write carries into the other half in that cycle.
- XLEN=64: the full counter is written; bits at or above COUNTER_WIDTH are dropped and read 0.
- Writes to 0xC03.. and 0xC83..:
  - no state changes;
  - CsrIllegal = 1 combinationally while CsrWriteEn is high;
  - CsrHit = 1.
- Writes to an unowned address are ignored; CsrHit = 0 and CsrIllegal = 0.
- Reset asserted mid-count clears every counter immediately, independent of clk. Counting resumes on the first edge after reset deasserts.

Optional Feature:
Macro ZIHPM_OVERFLOW_IRQ_EN (Sscofpmf-style overflow).
- When defined:
  - mhpmevent bit XLEN-1 is an OF (overflow) flag. Hardware sets it on the cycle a counter wraps to 0, and software may write it 0 or 1.
  - mhpmevent bit XLEN-2 is MINH, which inhibits counting the same way mcountinhibit does.
  - New output OverflowIrq, 1 bit, registered: equals the OR of all OF bits, updated on the edge after the wrap. Its reset value is 0.
  - If a software write to mhpmevent and a hardware overflow set of OF occur in the same cycle, the hardware set wins.
- When not defined: bits XLEN-1 and XLEN-2 read 0 and writes to them are ignored, the OverflowIrq port does not exist, and wrap-around is silent.

Test Plan:
- Reset then read: assert reset low with arbitrary prior state; read 0xB03, 0x323 and 0x320 -> all return 0; CsrHit=1 for 0xB03 and 0 for 0xB1F (index beyond NUM_COUNTERS).
- Event counting: write mhpmevent3=2; drive Events=8'b0000_0010 for 10 cycles and 0 for 5 cycles -> mhpmcounter3 reads 10. With mhpmevent4=0 on the same stimulus -> mhpmcounter4 reads 0.
- Inhibit and collision:
  - set mcountinhibit=0x8 for 5 cycles of an active event -> counter3 unchanged;
  - write mhpmcounter3=100 in a cycle where the event is active -> reads 100 next cycle, then 101 on the following cycle.
- XLEN=32 halves and wrap:
  - write 0xB03=0xFFFF_FFFF and 0xB83=0; one event -> low half reads 0 and high half reads 1;
  - with COUNTER_WIDTH=64, preload all ones; one event -> 0xB03 and 0xB83 both read 0.
- Illegal write: CsrWriteEn to 0xC03 with data 0x55 -> CsrIllegal=1, CsrHit=1, and 0xB03 is unchanged.
- ZIHPM_OVERFLOW_IRQ_EN defined:
  - preload counter3 with all ones; one event -> OF bit set and OverflowIrq=1 on the following cycle;
  - write OF=0 -> OverflowIrq=0 on the next cycle;
  - write OF=0 in the same cycle as a new wrap -> OF stays 1.
